// File: rtl/llc_stall_table.sv
// Table of LLC requests stalled on a busy set: lowest-free allocation,
// set-match lookup, oldest-first resume, retirement by index, sticky error flags.
module llc_stall_table #(
  parameter int DEPTH    = 4,
  parameter int SET_BITS = 9,
  parameter int TAG_BITS = 15,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rst_state,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  input  logic [SET_BITS-1:0] alloc_set,
  input  logic [TAG_BITS-1:0] alloc_tag,
  input  logic [SET_BITS-1:0] lookup_set,
  output logic                lookup_hit,
  output logic [IDX_W-1:0]    lookup_idx,
  output logic                resume_valid,
  input  logic                resume_ready,
  output logic [SET_BITS-1:0] resume_set,
  output logic [TAG_BITS-1:0] resume_tag,
  output logic [IDX_W-1:0]    resume_idx,
  input  logic                free_en,
  input  logic [IDX_W-1:0]    free_idx,
  output logic [IDX_W:0]      count,
  output logic                full,
  output logic                empty,
  output logic                overflow_err,
  output logic                free_err
);

  logic [DEPTH-1:0]    valid;
  logic [SET_BITS-1:0] set_mem [DEPTH];
  logic [TAG_BITS-1:0] tag_mem [DEPTH];
  // older[i][j] = 1 when entry i was allocated before entry j
  logic [DEPTH-1:0]    older [DEPTH];
  logic [IDX_W:0]      count_reg;
  logic                ovf_reg;
  logic                ferr_reg;

  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] is_oldest;
  logic [DEPTH-1:0] alloc_sel;
  logic [DEPTH-1:0] pop_mask;
  logic [DEPTH-1:0] free_mask;
  logic [DEPTH-1:0] rel_mask;
  logic [DEPTH-1:0] blocker [DEPTH];
  logic [IDX_W-1:0] alloc_idx;
  logic             alloc_fire;
  logic             pop_fire;
  logic             free_hit;
  logic             free_miss;
  logic [IDX_W:0]   rel_cnt;
  logic [IDX_W:0]   count_next;

  assign full         = (count_reg == (IDX_W+1)'(DEPTH));
  assign empty        = (count_reg == '0);
  assign alloc_ready  = !full;
  assign resume_valid = !empty;
  assign lookup_hit   = |match;
  assign count        = count_reg;
  assign overflow_err = ovf_reg;
  assign free_err     = ferr_reg;

  // Handshakes see only registered state; no ready-through from a same-cycle pop.
  assign alloc_fire = alloc_valid && alloc_ready;
  assign pop_fire   = resume_valid && resume_ready;
  assign free_hit   = free_en && valid[free_idx];
  assign free_miss  = free_en && !valid[free_idx];
  assign rel_mask   = pop_mask | free_mask;

  assign resume_set = resume_valid ? set_mem[resume_idx] : '0;
  assign resume_tag = resume_valid ? tag_mem[resume_idx] : '0;

  genvar gi, gj;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign match[gi]     = valid[gi] && (set_mem[gi] == lookup_set);
      assign alloc_sel[gi] = alloc_fire && (alloc_idx == IDX_W'(gi));
      assign pop_mask[gi]  = pop_fire && (resume_idx == IDX_W'(gi));
      assign free_mask[gi] = free_hit && (free_idx == IDX_W'(gi));
      for (gj = 0; gj < DEPTH; gj++) begin : g_age
        if (gi == gj) begin : g_diag
          assign blocker[gi][gj] = 1'b0;
        end else begin : g_off
          assign blocker[gi][gj] = valid[gj] && older[gj][gi];
        end
      end
      // Oldest: valid and no other valid entry predates it
      assign is_oldest[gi] = valid[gi] && !(|blocker[gi]);
    end
  endgenerate

  always_comb begin
    alloc_idx  = '0;
    lookup_idx = '0;
    resume_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i])    alloc_idx  = IDX_W'(i);
      if (match[i])     lookup_idx = IDX_W'(i);
      if (is_oldest[i]) resume_idx = IDX_W'(i);
    end
  end

  // A pop and a free of the same entry count as one release.
  always_comb begin
    rel_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel_cnt = rel_cnt + {{IDX_W{1'b0}}, rel_mask[i]};
    end
    count_next = count_reg + {{IDX_W{1'b0}}, alloc_fire} - rel_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      ferr_reg  <= 1'b0;
      valid     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        set_mem[i] <= '0;
        tag_mem[i] <= '0;
        older[i]   <= '0;
      end
    end else if (rst_state) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      ferr_reg  <= 1'b0;
      valid     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        set_mem[i] <= '0;
        tag_mem[i] <= '0;
        older[i]   <= '0;
      end
    end else begin
      count_reg <= count_next;
      if (alloc_valid && !alloc_ready) ovf_reg <= 1'b1;
      if (free_miss) ferr_reg <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_sel[i]) begin
          // New entry is younger than everyone: clear its row, others mark its column
          valid[i]   <= 1'b1;
          set_mem[i] <= alloc_set;
          tag_mem[i] <= alloc_tag;
          older[i]   <= '0;
        end else begin
          if (rel_mask[i]) valid[i] <= 1'b0;
          if (alloc_fire) older[i][alloc_idx] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_llc_stall_table.sv
// Directed and random checks of llc_stall_table against a queue-based model
// of the stalled-request table.
module tb_llc_stall_table;
  localparam int DEPTH = 4;
  localparam int SB    = 9;
  localparam int TB    = 15;
  localparam int IW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          rst_state;
  logic          alloc_valid;
  logic          alloc_ready;
  logic [SB-1:0] alloc_set;
  logic [TB-1:0] alloc_tag;
  logic [SB-1:0] lookup_set;
  logic          lookup_hit;
  logic [IW-1:0] lookup_idx;
  logic          resume_valid;
  logic          resume_ready;
  logic [SB-1:0] resume_set;
  logic [TB-1:0] resume_tag;
  logic [IW-1:0] resume_idx;
  logic          free_en;
  logic [IW-1:0] free_idx;
  logic [IW:0]   count;
  logic          full;
  logic          empty;
  logic          overflow_err;
  logic          free_err;

  always #5 clk = ~clk;

  llc_stall_table #(.DEPTH(DEPTH), .SET_BITS(SB), .TAG_BITS(TB)) dut (
    .clk(clk), .rst(rst), .rst_state(rst_state),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_set(alloc_set), .alloc_tag(alloc_tag),
    .lookup_set(lookup_set), .lookup_hit(lookup_hit), .lookup_idx(lookup_idx),
    .resume_valid(resume_valid), .resume_ready(resume_ready),
    .resume_set(resume_set), .resume_tag(resume_tag), .resume_idx(resume_idx),
    .free_en(free_en), .free_idx(free_idx), .count(count),
    .full(full), .empty(empty), .overflow_err(overflow_err), .free_err(free_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference: per-slot contents plus a queue of slot indices in allocation order
  logic          mvalid [DEPTH];
  logic [SB-1:0] mset   [DEPTH];
  logic [TB-1:0] mtag   [DEPTH];
  int            q[$];
  logic          movf;
  logic          mferr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      mvalid[i] = 1'b0;
      mset[i]   = '0;
      mtag[i]   = '0;
    end
    q.delete();
    movf  = 1'b0;
    mferr = 1'b0;
  endtask

  task automatic check_outputs(input string ph);
    int   n;
    int   lidx;
    logic hit;
    n    = q.size();
    hit  = 1'b0;
    lidx = 0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (mvalid[i] && mset[i] == lookup_set) begin
        hit  = 1'b1;
        lidx = i;
      end
    end
    chk({ph, "_count"},        32'(count),        32'(n));
    chk({ph, "_full"},         32'(full),         32'(n == DEPTH));
    chk({ph, "_empty"},        32'(empty),        32'(n == 0));
    chk({ph, "_alloc_ready"},  32'(alloc_ready),  32'(n != DEPTH));
    chk({ph, "_resume_valid"}, 32'(resume_valid), 32'(n != 0));
    chk({ph, "_resume_idx"},   32'(resume_idx),   (n != 0) ? 32'(q[0]) : 32'd0);
    chk({ph, "_resume_set"},   32'(resume_set),   (n != 0) ? 32'(mset[q[0]]) : 32'd0);
    chk({ph, "_resume_tag"},   32'(resume_tag),   (n != 0) ? 32'(mtag[q[0]]) : 32'd0);
    chk({ph, "_lookup_hit"},   32'(lookup_hit),   32'(hit));
    chk({ph, "_lookup_idx"},   32'(lookup_idx),   32'(lidx));
    chk({ph, "_overflow_err"}, 32'(overflow_err), 32'(movf));
    chk({ph, "_free_err"},     32'(free_err),     32'(mferr));
  endtask

  // Apply the current inputs to the model as the next clock edge will
  task automatic model_step();
    int n, aidx, pidx, fidx;
    int nq[$];
    if (rst_state) begin
      model_clear();
      return;
    end
    n    = q.size();
    aidx = -1;
    for (int i = 0; i < DEPTH; i++) if (!mvalid[i] && aidx < 0) aidx = i;
    if (alloc_valid && n == DEPTH) movf = 1'b1;
    pidx = (resume_ready && n > 0) ? q[0] : -1;
    fidx = -1;
    if (free_en) begin
      if (mvalid[free_idx]) fidx = int'(free_idx);
      else mferr = 1'b1;
    end
    foreach (q[k]) if (q[k] != pidx && q[k] != fidx) nq.push_back(q[k]);
    q = nq;
    if (pidx >= 0) mvalid[pidx] = 1'b0;
    if (fidx >= 0) mvalid[fidx] = 1'b0;
    if (alloc_valid && n < DEPTH) begin
      mvalid[aidx] = 1'b1;
      mset[aidx]   = alloc_set;
      mtag[aidx]   = alloc_tag;
      q.push_back(aidx);
    end
  endtask

  task automatic cycle(input logic rs, input logic av, input logic [SB-1:0] as,
                       input logic [TB-1:0] at, input logic rr, input logic fe,
                       input logic [IW-1:0] fi, input logic [SB-1:0] ls, input string ph);
    rst_state    = rs;
    alloc_valid  = av;
    alloc_set    = as;
    alloc_tag    = at;
    resume_ready = rr;
    free_en      = fe;
    free_idx     = fi;
    lookup_set   = ls;
    #1;
    check_outputs(ph);
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alloc(input logic [SB-1:0] s, input logic [TB-1:0] t);
    cycle(1'b0, 1'b1, s, t, 1'b0, 1'b0, '0, '0, "alloc");
  endtask

  task automatic peek(input logic [SB-1:0] ls);
    rst_state    = 1'b0;
    alloc_valid  = 1'b0;
    resume_ready = 1'b0;
    free_en      = 1'b0;
    lookup_set   = ls;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    model_clear();
    peek('0);
    alloc_set = '0;
    alloc_tag = '0;
    free_idx  = '0;
    check_outputs("reset");
    chk("reset_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("reset_empty",       32'(empty),       32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Basic allocate and lookup
    alloc(9'h10, 15'h1);
    alloc(9'h20, 15'h2);
    alloc(9'h10, 15'h3);
    peek(9'h10);
    chk("tp1_count",      32'(count),      32'd3);
    chk("tp1_lookup_hit", 32'(lookup_hit), 32'd1);
    chk("tp1_lookup_idx", 32'(lookup_idx), 32'd0);
    chk("tp1_resume_set", 32'(resume_set), 32'h10);
    chk("tp1_resume_tag", 32'(resume_tag), 32'h1);
    chk("tp1_resume_idx", 32'(resume_idx), 32'd0);

    // Full with a pop in the same cycle: allocate rejected, pop accepted
    alloc(9'h30, 15'h4);
    cycle(1'b0, 1'b1, 9'h40, 15'h5, 1'b1, 1'b0, '0, 9'h40, "fullpop");
    peek(9'h40);
    chk("tp2_overflow_err", 32'(overflow_err), 32'd1);
    chk("tp2_count",        32'(count),        32'd3);
    chk("tp2_no_0x40",      32'(lookup_hit),   32'd0);
    alloc(9'h50, 15'h6);
    peek(9'h50);
    chk("tp2_realloc_hit", 32'(lookup_hit), 32'd1);
    chk("tp2_realloc_idx", 32'(lookup_idx), 32'd0);

    // Out-of-order free, then pops keep allocation order
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, "clr");
    for (int i = 0; i < 4; i++) alloc(SB'(9'h100 + i), TB'(15'hA + i));
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 2'd1, '0, "free1");
    peek('0);
    chk("tp3_pop0_tag", 32'(resume_tag), 32'hA);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0, "pop");
    peek('0);
    chk("tp3_pop1_tag", 32'(resume_tag), 32'hC);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0, "pop");
    peek('0);
    chk("tp3_pop2_tag", 32'(resume_tag), 32'hD);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0, "pop");
    peek('0);
    chk("tp3_empty",      32'(empty),      32'd1);
    chk("tp3_resume_tag", 32'(resume_tag), 32'd0);
    chk("tp3_resume_set", 32'(resume_set), 32'd0);
    chk("tp3_resume_idx", 32'(resume_idx), 32'd0);

    // Free of an invalid entry, then synchronous clear
    alloc(9'h7, 15'h70);
    alloc(9'h8, 15'h80);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 2'd2, '0, "freebad");
    peek(9'h7);
    chk("tp4_free_err", 32'(free_err), 32'd1);
    chk("tp4_count",    32'(count),    32'd2);
    cycle(1'b1, 1'b1, 9'h9, 15'h90, 1'b1, 1'b1, 2'd0, 9'h7, "rst_state");
    peek(9'h7);
    chk("tp4_clr_free_err", 32'(free_err),   32'd0);
    chk("tp4_clr_count",    32'(count),      32'd0);
    chk("tp4_clr_hit",      32'(lookup_hit), 32'd0);

    // Pop and free of the same oldest entry in one cycle
    alloc(9'h1, 15'h11);
    alloc(9'h2, 15'h12);
    alloc(9'h3, 15'h13);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 2'd0, '0, "popfree");
    peek('0);
    chk("tp5_count",      32'(count),      32'd2);
    chk("tp5_free_err",   32'(free_err),   32'd0);
    chk("tp5_resume_idx", 32'(resume_idx), 32'd1);
    chk("tp5_resume_tag", 32'(resume_tag), 32'h12);

    // Asynchronous reset between edges
    alloc(9'h4, 15'h14);
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;

    // Random traffic against the model
    for (int c = 0; c < 10000; c++) begin
      cycle(($urandom_range(0, 499) == 0),
            ($urandom_range(0, 1) == 1),
            SB'($urandom_range(0, 7)),
            TB'($urandom),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0),
            IW'($urandom_range(0, DEPTH - 1)),
            SB'($urandom_range(0, 7)),
            "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
